hbmc_rx_burst_seq: RTL and testbench
====================================

Name: hbmc_rx_burst_seq

Overview:
Write-side sequencer for the elastic buffer on the HyperBus read-data path. It runs in the capture clock domain, clk_din. It accepts one burst command at a time, counts captured data words against the commanded length, and tags each word with valid and last flags. It also detects stalled RWDS strobing and drives an explicit word on every cycle. This is required because the elastic buffer writes unconditionally each clk_din cycle, so idle slots must carry valid=0.

Parameters:
DATA_WIDTH, 16, captured data word width.
LEN_WIDTH, 8, burst length field width; a burst holds 1..2^LEN_WIDTH words.
FIRST_TIMEOUT, 64, cycles allowed from command accept to the first captured word.
GAP_TIMEOUT, 8, cycles allowed between consecutive captured words within a burst.

Ports:
clk_din  input  1  capture-domain clock, same clock as the elastic buffer write port.
rstn_0  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  burst command valid.
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
cmd_len  input  LEN_WIDTH  burst length minus one.
cmd_abort  input  1  terminate the current burst.
cap_valid  input  1  captured word strobe from the deserializer.
cap_data  input  DATA_WIDTH  captured word.
buf_din  output  DATA_WIDTH+2  word to the elastic buffer, packed {last, valid, data}.
busy  output  1  high in ARMED, ACTIVE and FLUSH.
done  output  1  one-cycle pulse at burst end, whether normal, timeout or abort.
err_timeout  output  1  one-cycle pulse when a burst ends by timeout.
err_stray  output  1  one-cycle pulse when cap_valid arrives in IDLE.

Behaviour:
- States:
  - IDLE: cmd_ready=1.
  - ARMED: command accepted, waiting for the first word.
  - ACTIVE: at least one word received, more expected.
  - FLUSH: one cycle, emits the terminator word.
- Reset values: state=IDLE, buf_din=0, done=0, err_timeout=0, err_stray=0, remaining=0, timer=0. cmd_ready=1 and busy=0 while in reset, since both are decoded from state.
- Command accept (IDLE, cmd_valid=1): remaining<=cmd_len, timer<=0, go to ARMED. cmd_ready is low in all other states, so there are no back-to-back commands without one IDLE cycle.
- Word capture (ARMED or ACTIVE, cap_valid=1):
  - Next cycle, buf_din={remaining==0, 1, cap_data}. Latency is exactly 1 clock.
  - timer<=0. If remaining==0, go to IDLE with done=1 in the same cycle the last word appears on buf_din.
  - Otherwise remaining decrements and the state goes to ACTIVE.
- No word (ARMED or ACTIVE, cap_valid=0):
  - buf_din={0,0,0}, timer increments.
  - Timeout fires when timer reaches FIRST_TIMEOUT-1 in ARMED, or GAP_TIMEOUT-1 in ACTIVE: go to FLUSH.
- FLUSH:
  - buf_din={1,0,0}, the terminator. The downstream side recognises last=1 with valid=0 as a truncated burst.
  - done=1. err_timeout=1 if the burst was terminated by timeout. Go to IDLE.
- cmd_abort in ARMED or ACTIVE: go to FLUSH next cycle with err_timeout=0. cmd_abort in IDLE or FLUSH is ignored.
- Simultaneous events:
  - cap_valid with the final word plus cmd_abort, or plus timer expiry, in the same cycle: the word wins, the burst completes normally, no FLUSH.
  - cap_valid with a non-final word plus cmd_abort: the word is written, then FLUSH.
- cap_valid in IDLE or FLUSH: word dropped, buf_din valid=0, err_stray pulses one cycle later.
- Idle output: buf_din is {0,0,0} on every cycle that does not carry a captured word or a terminator.
- Width rules:
  - remaining is LEN_WIDTH bits, so cmd_len=all-ones means 2^LEN_WIDTH words.
  - timer is clog2(max(FIRST_TIMEOUT,GAP_TIMEOUT)) bits, saturating, never wraps.
- Asynchronous reset mid-burst: immediate return to IDLE with all outputs at reset values. No terminator is emitted. The downstream side is reset by the same arstn source.

Test Plan:
- Normal burst: cmd_len=3, four contiguous cap_valid words 0xA001..0xA004 -> buf_din valid words one cycle later, last=1 only on 0xA004, done pulse coincident with 0xA004, cmd_ready back to 1 on the next cycle.
- Gapped burst: cmd_len=1, words separated by GAP_TIMEOUT-2 idle cycles -> both words delivered, no timeout, idle cycles show buf_din=0.
- First-word timeout: cmd_len=7, no cap_valid for FIRST_TIMEOUT cycles -> FLUSH word {1,0,0}, done=1 and err_timeout=1 together, state back to IDLE.
- Abort race: cmd_len=0, cap_valid and cmd_abort in the same cycle -> word delivered with last=1, no terminator, err_timeout=0. Then cmd_len=2 with abort after one word -> one valid word, then {1,0,0}.
- Max length and stray words: cmd_len=0xFF, 256 words -> last=1 on word 256 only. Extra cap_valid after done -> dropped, err_stray pulses once.
- Reset mid-burst: assert rstn_0 after 2 of 5 words -> buf_din=0, busy=0 immediately. New command after release operates normally.

Source files
------------

// File: rtl/hbmc_rx_burst_seq.sv
// Write-side sequencer for the HyperBus read-data elastic buffer (clk_din domain).
// Counts captured words against the commanded length and emits one tagged word every cycle.
module hbmc_rx_burst_seq #(
   parameter int DATA_WIDTH    = 16,
   parameter int LEN_WIDTH     = 8,
   parameter int FIRST_TIMEOUT = 64,
   parameter int GAP_TIMEOUT   = 8
) (
   input  logic                  clk_din,
   input  logic                  rstn_0,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_abort,
   input  logic                  cap_valid,
   input  logic [DATA_WIDTH-1:0] cap_data,
   output logic [DATA_WIDTH+1:0] buf_din,
   output logic                  busy,
   output logic                  done,
   output logic                  err_timeout,
   output logic                  err_stray
);

   localparam int TMR_MAX = (FIRST_TIMEOUT > GAP_TIMEOUT) ? FIRST_TIMEOUT : GAP_TIMEOUT;
   localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] FIRST_LIM = TMR_W'(FIRST_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LIM   = TMR_W'(GAP_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_SAT   = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_ACTIVE = 2'd2,
      S_FLUSH  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic                  tmo_q, tmo_d;
   logic [DATA_WIDTH+1:0] buf_din_q, buf_din_d;
   logic                  done_q, done_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_stray_q, err_stray_d;

   logic                  in_burst;
   logic                  final_word;
   logic                  expired;
   logic [TMR_W-1:0]      timer_lim;

   assign in_burst   = (state_q == S_ARMED) || (state_q == S_ACTIVE);
   assign final_word = (remaining_q == '0);
   assign timer_lim  = (state_q == S_ARMED) ? FIRST_LIM : GAP_LIM;
   assign expired    = (timer_q >= timer_lim);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_din or negedge rstn_0) begin
      if (!rstn_0) begin
         state_q       <= S_IDLE;
         remaining_q   <= '0;
         timer_q       <= '0;
         tmo_q         <= 1'b0;
         buf_din_q     <= '0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_stray_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         timer_q       <= timer_d;
         tmo_q         <= tmo_d;
         buf_din_q     <= buf_din_d;
         done_q        <= done_d;
         err_timeout_q <= err_timeout_d;
         err_stray_q   <= err_stray_d;
      end
   end

   // Next-state logic; a captured word always takes priority over abort or timer expiry.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      tmo_d       = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d     = S_ARMED;
               remaining_d = cmd_len;
               timer_d     = '0;
               tmo_d       = 1'b0;
            end
         end
         S_ARMED, S_ACTIVE: begin
            if (cap_valid) begin
               timer_d = '0;
               if (final_word) begin
                  state_d = S_IDLE;
               end else begin
                  remaining_d = remaining_q - 1'b1;
                  state_d     = cmd_abort ? S_FLUSH : S_ACTIVE;
                  tmo_d       = 1'b0;
               end
            end else if (cmd_abort) begin
               state_d = S_FLUSH;
               tmo_d   = 1'b0;
            end else if (expired) begin
               state_d = S_FLUSH;
               tmo_d   = 1'b1;
            end else begin
               timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + 1'b1;
            end
         end
         S_FLUSH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: the word for the next cycle, so each buffer slot lags its decision by one clock.
   always_comb begin
      buf_din_d     = '0;
      done_d        = 1'b0;
      err_timeout_d = 1'b0;
      err_stray_d   = 1'b0;
      if (in_burst) begin
         if (cap_valid) begin
            buf_din_d = {final_word, 1'b1, cap_data};
            done_d    = final_word;
         end
      end else if (state_q == S_FLUSH) begin
         // Terminator: last with no valid marks a truncated burst downstream.
         buf_din_d     = {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
         done_d        = 1'b1;
         err_timeout_d = tmo_q;
         err_stray_d   = cap_valid;
      end else begin
         err_stray_d = cap_valid;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign buf_din     = buf_din_q;
   assign done        = done_q;
   assign err_timeout = err_timeout_q;
   assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_hbmc_rx_burst_seq.sv
// Table-driven bench for hbmc_rx_burst_seq: each record drives one cycle and lists the
// outputs expected after that clock edge; reset mid-burst is a hand-written sequence.
module tb_hbmc_rx_burst_seq;

   localparam int DW = 16;
   localparam int LW = 8;

   // Flag field order: {done, err_timeout, err_stray, cmd_ready, busy}
   localparam logic [4:0] F_IDLE       = 5'b00010;
   localparam logic [4:0] F_BUSY       = 5'b00001;
   localparam logic [4:0] F_DONE       = 5'b10010;
   localparam logic [4:0] F_DONE_TO    = 5'b11010;
   localparam logic [4:0] F_STRAY      = 5'b00110;
   localparam logic [4:0] F_DONE_STRAY = 5'b10110;

   typedef struct {
      string          tag;
      logic           cv;
      logic [LW-1:0]  len;
      logic           ab;
      logic           cap;
      logic [DW-1:0]  dat;
      logic [DW+1:0]  exp_buf;
      logic [4:0]     exp_flg;
   } vec_t;

   logic          clk_din = 1'b0;
   logic          rstn_0  = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len   = '0;
   logic          cmd_abort = 1'b0;
   logic          cap_valid = 1'b0;
   logic [DW-1:0] cap_data  = '0;
   logic [DW+1:0] buf_din;
   logic          busy, done, err_timeout, err_stray;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vq[$];

   hbmc_rx_burst_seq #(
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIRST_TIMEOUT(64), .GAP_TIMEOUT(8)
   ) dut (
      .clk_din(clk_din), .rstn_0(rstn_0),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
      .cap_valid(cap_valid), .cap_data(cap_data),
      .buf_din(buf_din), .busy(busy), .done(done),
      .err_timeout(err_timeout), .err_stray(err_stray)
   );

   always #5 clk_din = ~clk_din;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string tag, input logic cv, input logic [LW-1:0] len,
                               input logic ab, input logic cap, input logic [DW-1:0] dat,
                               input logic [DW+1:0] eb, input logic [4:0] ef);
      vec_t v;
      v.tag = tag; v.cv = cv; v.len = len; v.ab = ab; v.cap = cap; v.dat = dat;
      v.exp_buf = eb; v.exp_flg = ef;
      return v;
   endfunction

   function automatic void add(input string tag, input logic cv, input logic [LW-1:0] len,
                               input logic ab, input logic cap, input logic [DW-1:0] dat,
                               input logic [DW+1:0] eb, input logic [4:0] ef);
      vq.push_back(mk(tag, cv, len, ab, cap, dat, eb, ef));
   endfunction

   // Called at a negedge: drive, let one rising edge pass, compare at the next negedge.
   task automatic apply(input vec_t v, input int idx);
      cmd_valid = v.cv; cmd_len = v.len; cmd_abort = v.ab;
      cap_valid = v.cap; cap_data = v.dat;
      @(posedge clk_din);
      @(negedge clk_din);
      check($sformatf("%s[%0d] buf_din", v.tag, idx), 32'(buf_din), 32'(v.exp_buf));
      check($sformatf("%s[%0d] flags", v.tag, idx),
            32'({done, err_timeout, err_stray, cmd_ready, busy}), 32'(v.exp_flg));
   endtask

   task automatic check_reset_state(input string name);
      check({name, " buf_din"}, 32'(buf_din), 32'h0);
      check({name, " flags"}, 32'({done, err_timeout, err_stray, cmd_ready, busy}), 32'(F_IDLE));
   endtask

   initial begin
      // Normal burst
      add("norm", 1, 8'd3, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("norm", 0, 8'd0, 0, 1, 16'hA001, 18'h1A001, F_BUSY);
      add("norm", 0, 8'd0, 0, 1, 16'hA002, 18'h1A002, F_BUSY);
      add("norm", 0, 8'd0, 0, 1, 16'hA003, 18'h1A003, F_BUSY);
      add("norm", 0, 8'd0, 0, 1, 16'hA004, 18'h3A004, F_DONE);
      add("norm", 0, 8'd0, 0, 0, 16'h0,    18'h00000, F_IDLE);
      // Gapped burst, GAP_TIMEOUT-2 idle cycles between words
      add("gap", 1, 8'd1, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("gap", 0, 8'd0, 0, 1, 16'hB001, 18'h1B001, F_BUSY);
      for (int k = 0; k < 6; k++) add("gap_idle", 0, 8'd0, 0, 0, 16'h0, 18'h00000, F_BUSY);
      add("gap", 0, 8'd0, 0, 1, 16'hB002, 18'h3B002, F_DONE);
      // Gap timeout boundary: seven idle cycles tolerated, the eighth expires
      add("gapto", 1, 8'd2, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("gapto", 0, 8'd0, 0, 1, 16'hC001, 18'h1C001, F_BUSY);
      for (int k = 0; k < 8; k++) add("gapto_idle", 0, 8'd0, 0, 0, 16'h0, 18'h00000, F_BUSY);
      add("gapto_term", 0, 8'd0, 0, 0, 16'h0, 18'h20000, F_DONE_TO);
      // First-word timeout after FIRST_TIMEOUT silent cycles
      add("firstto", 1, 8'd7, 0, 0, 16'h0, 18'h00000, F_BUSY);
      for (int k = 0; k < 64; k++) add("firstto_idle", 0, 8'd0, 0, 0, 16'h0, 18'h00000, F_BUSY);
      add("firstto_term", 0, 8'd0, 0, 0, 16'h0, 18'h20000, F_DONE_TO);
      add("firstto_after", 0, 8'd0, 0, 0, 16'h0, 18'h00000, F_IDLE);
      // Final word arriving on the expiry cycle wins
      add("race_to", 1, 8'd0, 0, 0, 16'h0, 18'h00000, F_BUSY);
      for (int k = 0; k < 63; k++) add("race_to_idle", 0, 8'd0, 0, 0, 16'h0, 18'h00000, F_BUSY);
      add("race_to_word", 0, 8'd0, 0, 1, 16'hD004, 18'h3D004, F_DONE);
      // Final word with abort: normal completion
      add("abort_a", 1, 8'd0, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("abort_a", 0, 8'd0, 1, 1, 16'hD001, 18'h3D001, F_DONE);
      add("abort_a", 0, 8'd0, 0, 0, 16'h0,    18'h00000, F_IDLE);
      // Abort after one word
      add("abort_b", 1, 8'd2, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("abort_b", 0, 8'd0, 0, 1, 16'hD002, 18'h1D002, F_BUSY);
      add("abort_b", 0, 8'd0, 1, 0, 16'h0,    18'h00000, F_BUSY);
      add("abort_b", 0, 8'd0, 0, 0, 16'h0,    18'h20000, F_DONE);
      // Non-final word with abort, then a stray word during FLUSH
      add("abort_c", 1, 8'd2, 0, 0, 16'h0,    18'h00000, F_BUSY);
      add("abort_c", 0, 8'd0, 1, 1, 16'hD003, 18'h1D003, F_BUSY);
      add("abort_c", 0, 8'd0, 0, 1, 16'h5555, 18'h20000, F_DONE_STRAY);
      add("abort_c", 0, 8'd0, 0, 0, 16'h0,    18'h00000, F_IDLE);
      add("abort_idle", 0, 8'd0, 1, 0, 16'h0, 18'h00000, F_IDLE);
      // Max length burst, then a stray word in IDLE
      add("max", 1, 8'hFF, 0, 0, 16'h0, 18'h00000, F_BUSY);
      for (int k = 0; k < 256; k++) begin
         logic [DW-1:0] d;
         d = 16'h1000 + 16'(k);
         add("max", 0, 8'd0, 0, 1, d, {(k == 255), 1'b1, d}, (k == 255) ? F_DONE : F_BUSY);
      end
      add("stray", 0, 8'd0, 0, 1, 16'hEEEE, 18'h00000, F_STRAY);
      add("stray", 0, 8'd0, 0, 0, 16'h0,    18'h00000, F_IDLE);

      #2;
      check_reset_state("in_reset");
      @(negedge clk_din);
      @(negedge clk_din);
      rstn_0 = 1'b1;

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // Reset mid-burst after 2 of 5 words
      apply(mk("rst", 1, 8'd4, 0, 0, 16'h0,    18'h00000, F_BUSY), 0);
      apply(mk("rst", 0, 8'd0, 0, 1, 16'hE001, 18'h1E001, F_BUSY), 1);
      apply(mk("rst", 0, 8'd0, 0, 1, 16'hE002, 18'h1E002, F_BUSY), 2);
      cap_valid = 1'b1; cap_data = 16'hE003;
      rstn_0 = 1'b0;
      #1;
      check_reset_state("rst_async");
      @(posedge clk_din);
      #1;
      check_reset_state("rst_held");
      @(negedge clk_din);
      cap_valid = 1'b0;
      rstn_0 = 1'b1;
      apply(mk("post_rst", 1, 8'd1, 0, 0, 16'h0,    18'h00000, F_BUSY), 0);
      apply(mk("post_rst", 0, 8'd0, 0, 1, 16'hF001, 18'h1F001, F_BUSY), 1);
      apply(mk("post_rst", 0, 8'd0, 0, 1, 16'hF002, 18'h3F002, F_DONE), 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
